dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 30 +++
 rtl/dmem_arbiter_if.sv | 47 ++++
 rtl/dmem_prio_sel.sv | 55 +++++
 rtl/dmem_arbiter.sv | 93 +++++++++
 tb/tb_dmem_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared memory command encodings, port ids and helpers
// Purpose: single home for the data-memory command set, the idle command,
//          the requester id enum and the store-command test.
// Ports:   none (package).
package dmem_arbiter_pkg;

    // Memory command encodings; bit 3 set marks a store.
    localparam logic [3:0] MEM_IDLE = 4'b0000;
    localparam logic [3:0] MEM_LB   = 4'b0001;
    localparam logic [3:0] MEM_LH   = 4'b0010;
    localparam logic [3:0] MEM_LW   = 4'b0011;
    localparam logic [3:0] MEM_LBU  = 4'b0100;
    localparam logic [3:0] MEM_LHU  = 4'b0101;
    localparam logic [3:0] MEM_SB   = 4'b1001;
    localparam logic [3:0] MEM_SH   = 4'b1010;
    localparam logic [3:0] MEM_SW   = 4'b1011;

    // Driven onto the memory when nothing was granted: neither load nor store.
    localparam logic [3:0] CMD_IDLE = MEM_IDLE;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    function automatic logic is_store(input logic [3:0] cmd);
        return (cmd == MEM_SB) || (cmd == MEM_SH) || (cmd == MEM_SW);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester, response and data-memory bus of the arbiter
// Purpose: bundles both requester ports, their grant/response signals and the
//          data-memory side into one interface.
// Ports:   P0_*/P1_*      requests (req, cmd, addr, din)
//          ARB_p*_gnt     combinational grants
//          ARB_p*_rvalid  response pulses, ARB_rdata load data
//          ARB_mem_*      registered memory drive, DM_mem_dout memory read data
// Modports: slave (arbiter side), master (requesters + memory side).
interface dmem_arbiter_if;

    logic        P0_req;
    logic [3:0]  P0_cmd;
    logic [31:0] P0_addr;
    logic [31:0] P0_din;
    logic        P1_req;
    logic [3:0]  P1_cmd;
    logic [31:0] P1_addr;
    logic [31:0] P1_din;

    logic        ARB_p0_gnt;
    logic        ARB_p1_gnt;
    logic        ARB_p0_rvalid;
    logic        ARB_p1_rvalid;
    logic [31:0] ARB_rdata;

    logic [3:0]  ARB_mem_cmd;
    logic [31:0] ARB_mem_addr;
    logic [31:0] ARB_mem_din;
    logic [31:0] DM_mem_dout;

    modport slave (
        input  P0_req, P0_cmd, P0_addr, P0_din,
        input  P1_req, P1_cmd, P1_addr, P1_din,
        output ARB_p0_gnt, ARB_p1_gnt, ARB_p0_rvalid, ARB_p1_rvalid, ARB_rdata,
        output ARB_mem_cmd, ARB_mem_addr, ARB_mem_din,
        input  DM_mem_dout
    );

    modport master (
        output P0_req, P0_cmd, P0_addr, P0_din,
        output P1_req, P1_cmd, P1_addr, P1_din,
        input  ARB_p0_gnt, ARB_p1_gnt, ARB_p0_rvalid, ARB_p1_rvalid, ARB_rdata,
        input  ARB_mem_cmd, ARB_mem_addr, ARB_mem_din,
        output DM_mem_dout
    );

endinterface

// File: rtl/dmem_prio_sel.sv
// rtl/dmem_prio_sel.sv - port-0-priority grant select with bounded port-0 bursts
// Purpose: grants port 0 by default; after MAX_BURST consecutive contested
//          port-0 grants, port 1 is forced through once.
// Ports:   clk, rst      clock, synchronous active-high reset
//          p0_req/p1_req requests
//          p0_gnt/p1_gnt combinational one-hot grants (both 0 in reset)
module dmem_prio_sel #(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic p0_req,
    input  logic p1_req,
    output logic p0_gnt,
    output logic p1_gnt
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    logic [CW-1:0] burst_cnt;
    logic [CW-1:0] burst_cnt_nxt;
    logic          force_p1;

    always_comb begin
        p0_gnt        = 1'b0;
        p1_gnt        = 1'b0;
        burst_cnt_nxt = burst_cnt;
        force_p1      = (burst_cnt == CNT_MAX);

        if (!rst) begin
            if (p0_req && !(p1_req && force_p1)) begin
                p0_gnt = 1'b1;
            end else if (p1_req) begin
                p1_gnt = 1'b1;
            end
        end

        // The count only measures how long port 1 has been starved by port 0.
        if (p1_gnt || !p1_req) begin
            burst_cnt_nxt = '0;
        end else if (p0_gnt && !force_p1) begin
            burst_cnt_nxt = burst_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt <= '0;
        end else begin
            burst_cnt <= burst_cnt_nxt;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter with two-stage response pipeline
// Purpose: picks one requester per cycle, registers its command into the
//          memory drive (stage A), then captures memory read data and pulses
//          the matching rvalid one cycle later (stage B).
// Ports:   clk, rst  clock, synchronous active-high reset
//          bus       dmem_arbiter_if.slave (requests, grants, responses, memory)
// Params:  MAX_BURST max consecutive contested port-0 grants before port 1 wins.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    logic        p0_gnt;
    logic        p1_gnt;

    // Stage A: memory drive plus who it belongs to.
    logic        a_valid;
    port_e       a_port;
    logic [3:0]  mem_cmd;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;

    // Stage B: response.
    logic        p0_rvalid;
    logic        p1_rvalid;
    logic [31:0] rdata;

    dmem_prio_sel #(
        .MAX_BURST (MAX_BURST)
    ) u_prio_sel (
        .clk    (clk),
        .rst    (rst),
        .p0_req (bus.P0_req),
        .p1_req (bus.P1_req),
        .p0_gnt (p0_gnt),
        .p1_gnt (p1_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid  <= 1'b0;
            a_port   <= PORT0;
            mem_cmd  <= CMD_IDLE;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            a_valid <= p0_gnt || p1_gnt;
            if (p0_gnt) begin
                a_port   <= PORT0;
                mem_cmd  <= bus.P0_cmd;
                mem_addr <= bus.P0_addr;
                mem_din  <= bus.P0_din;
            end else if (p1_gnt) begin
                a_port   <= PORT1;
                mem_cmd  <= bus.P1_cmd;
                mem_addr <= bus.P1_addr;
                mem_din  <= bus.P1_din;
            end else begin
                // Address/data are left as-is; an idle command makes them inert.
                mem_cmd  <= CMD_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            rdata     <= '0;
        end else begin
            p0_rvalid <= a_valid && (a_port == PORT0);
            p1_rvalid <= a_valid && (a_port == PORT1);
            if (a_valid) begin
                rdata <= bus.DM_mem_dout;
            end
        end
    end

    assign bus.ARB_p0_gnt    = p0_gnt;
    assign bus.ARB_p1_gnt    = p1_gnt;
    assign bus.ARB_mem_cmd   = mem_cmd;
    assign bus.ARB_mem_addr  = mem_addr;
    assign bus.ARB_mem_din   = mem_din;
    assign bus.ARB_p0_rvalid = p0_rvalid;
    assign bus.ARB_p1_rvalid = p1_rvalid;
    assign bus.ARB_rdata     = rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int MAX_BURST_A = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if ifa ();
    dmem_arbiter_if ifb ();

    dmem_arbiter #(.MAX_BURST(MAX_BURST_A)) dut4 (.clk(clk), .rst(rst), .bus(ifa));
    dmem_arbiter #(.MAX_BURST(1))           dut1 (.clk(clk), .rst(rst), .bus(ifb));

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] cmd,
                                          input logic [1:0] off, input logic [31:0] din);
        logic [31:0] w;
        w = old;
        case (cmd)
            MEM_SB:  w[8*off +: 8] = din[7:0];
            MEM_SH:  w[16*off[1] +: 16] = din[15:0];
            MEM_SW:  w = din;
            default: ;
        endcase
        return w;
    endfunction

    // Data memory behind dut4: combinational read, write at the edge, cleared by rst.
    logic [31:0] mem_a [256];
    assign ifa.DM_mem_dout = mem_a[ifa.ARB_mem_addr[9:2]];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= '0;
        end else if (is_store(ifa.ARB_mem_cmd)) begin
            mem_a[ifa.ARB_mem_addr[9:2]] <= merge(mem_a[ifa.ARB_mem_addr[9:2]], ifa.ARB_mem_cmd,
                                                  ifa.ARB_mem_addr[1:0], ifa.ARB_mem_din);
        end
    end
    assign ifb.DM_mem_dout = 32'hC0FFEE00 ^ ifb.ARB_mem_addr;

    task automatic set_a(input logic r0, input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] d1);
        ifa.P0_req = r0; ifa.P0_cmd = c0; ifa.P0_addr = a0; ifa.P0_din = d0;
        ifa.P1_req = r1; ifa.P1_cmd = c1; ifa.P1_addr = a1; ifa.P1_din = d1;
    endtask

    task automatic set_b(input logic r0, input logic r1);
        ifb.P0_req = r0; ifb.P0_cmd = MEM_LW; ifb.P0_addr = 32'h8; ifb.P0_din = '0;
        ifb.P1_req = r1; ifb.P1_cmd = MEM_LW; ifb.P1_addr = 32'hC; ifb.P1_din = '0;
    endtask

    task automatic idle_a;
        set_a(1'b0, MEM_IDLE, '0, '0, 1'b0, MEM_IDLE, '0, '0);
    endtask

    task automatic test_reset;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            rst = 1'b1;
            set_a(1'b1, MEM_LW, 32'h10, '0, 1'b1, MEM_LW, 32'h14, '0);
            set_b(1'b1, 1'b1);
            #1;
            checks++;
            if ({ifa.ARB_p0_gnt, ifa.ARB_p1_gnt} !== 2'b00) begin
                errors++; $display("FAIL reset_gnt_a: got %b%b expected 00", ifa.ARB_p0_gnt, ifa.ARB_p1_gnt);
            end
            checks++;
            if ({ifb.ARB_p0_gnt, ifb.ARB_p1_gnt} !== 2'b00) begin
                errors++; $display("FAIL reset_gnt_b: got %b%b expected 00", ifb.ARB_p0_gnt, ifb.ARB_p1_gnt);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (ifa.ARB_mem_cmd !== MEM_IDLE || ifa.ARB_mem_addr !== 32'h0 || ifa.ARB_mem_din !== 32'h0) begin
            errors++; $display("FAIL reset_mem: got cmd %h addr %h din %h expected 0 0 0",
                               ifa.ARB_mem_cmd, ifa.ARB_mem_addr, ifa.ARB_mem_din);
        end
        checks++;
        if (ifa.ARB_rdata !== 32'h0 || ifa.ARB_p0_rvalid !== 1'b0 || ifa.ARB_p1_rvalid !== 1'b0) begin
            errors++; $display("FAIL reset_resp: got rdata %h rv %b%b expected 0 00",
                               ifa.ARB_rdata, ifa.ARB_p0_rvalid, ifa.ARB_p1_rvalid);
        end
        rst = 1'b0;
        idle_a();
        set_b(1'b0, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_store_load;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0)      set_a(1'b1, MEM_SW, 32'h10, 32'hDEADBEEF, 1'b0, MEM_IDLE, '0, '0);
            else if (k == 1) set_a(1'b1, MEM_LW, 32'h10, 32'h0, 1'b0, MEM_IDLE, '0, '0);
            else             idle_a();
            #1;
            checks++;
            if ({ifa.ARB_p0_gnt, ifa.ARB_p1_gnt} !== {k < 2, 1'b0}) begin
                errors++; $display("FAIL sl_gnt[%0d]: got %b%b expected %b0", k, ifa.ARB_p0_gnt, ifa.ARB_p1_gnt, k < 2);
            end
            checks++;
            if ({ifa.ARB_p0_rvalid, ifa.ARB_p1_rvalid} !== {(k == 2 || k == 3), 1'b0}) begin
                errors++; $display("FAIL sl_rvalid[%0d]: got %b%b expected %b0", k, ifa.ARB_p0_rvalid,
                                   ifa.ARB_p1_rvalid, (k == 2 || k == 3));
            end
            if (k == 1) begin
                checks++;
                if (ifa.ARB_mem_cmd !== MEM_SW || ifa.ARB_mem_addr !== 32'h10 || ifa.ARB_mem_din !== 32'hDEADBEEF) begin
                    errors++; $display("FAIL sl_mem_drive: got %h %h %h expected b 10 deadbeef",
                                       ifa.ARB_mem_cmd, ifa.ARB_mem_addr, ifa.ARB_mem_din);
                end
            end
            if (k >= 3) begin
                checks++;
                if (ifa.ARB_rdata !== 32'hDEADBEEF) begin
                    errors++; $display("FAIL sl_rdata[%0d]: got %h expected deadbeef", k, ifa.ARB_rdata);
                end
            end
            if (k == 4) begin
                checks++;
                if (ifa.ARB_mem_cmd !== MEM_IDLE) begin
                    errors++; $display("FAIL sl_idle_cmd: got %h expected 0", ifa.ARB_mem_cmd);
                end
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_contention4;
        logic e1;
        logic ev1;
        logic ev0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            set_a(1'b1, MEM_LW, 32'h100, '0, 1'b1, MEM_LW, 32'h104, '0);
            #1;
            e1 = ((k % (MAX_BURST_A + 1)) == MAX_BURST_A);
            checks++;
            if ({ifa.ARB_p0_gnt, ifa.ARB_p1_gnt} !== {!e1, e1}) begin
                errors++; $display("FAIL burst4_gnt[%0d]: got %b%b expected %b%b", k,
                                   ifa.ARB_p0_gnt, ifa.ARB_p1_gnt, !e1, e1);
            end
            ev0 = (k >= 2) && (((k - 2) % (MAX_BURST_A + 1)) != MAX_BURST_A);
            ev1 = (k >= 2) && (((k - 2) % (MAX_BURST_A + 1)) == MAX_BURST_A);
            checks++;
            if ({ifa.ARB_p0_rvalid, ifa.ARB_p1_rvalid} !== {ev0, ev1}) begin
                errors++; $display("FAIL burst4_rvalid[%0d]: got %b%b expected %b%b", k,
                                   ifa.ARB_p0_rvalid, ifa.ARB_p1_rvalid, ev0, ev1);
            end
        end
        @(negedge clk);
        idle_a();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_alternate1;
        logic e1;
        logic ev0;
        logic ev1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            set_b(1'b1, 1'b1);
            #1;
            e1 = (k % 2) == 1;
            checks++;
            if ({ifb.ARB_p0_gnt, ifb.ARB_p1_gnt} !== {!e1, e1}) begin
                errors++; $display("FAIL alt_gnt[%0d]: got %b%b expected %b%b", k,
                                   ifb.ARB_p0_gnt, ifb.ARB_p1_gnt, !e1, e1);
            end
            ev0 = (k >= 2) && ((k % 2) == 0);
            ev1 = (k >= 2) && ((k % 2) == 1);
            checks++;
            if ({ifb.ARB_p0_rvalid, ifb.ARB_p1_rvalid} !== {ev0, ev1}) begin
                errors++; $display("FAIL alt_rvalid[%0d]: got %b%b expected %b%b", k,
                                   ifb.ARB_p0_rvalid, ifb.ARB_p1_rvalid, ev0, ev1);
            end
        end
        @(negedge clk);
        set_b(1'b0, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_byte_store;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0)      set_a(1'b0, MEM_IDLE, '0, '0, 1'b1, MEM_SW, 32'h20, 32'h11223344);
            else if (k == 1) set_a(1'b0, MEM_IDLE, '0, '0, 1'b1, MEM_SB, 32'h21, 32'h000000AA);
            else if (k == 2) set_a(1'b0, MEM_IDLE, '0, '0, 1'b1, MEM_LW, 32'h20, 32'h0);
            else             idle_a();
            #1;
            checks++;
            if ({ifa.ARB_p0_gnt, ifa.ARB_p1_gnt, ifa.ARB_p0_rvalid, ifa.ARB_p1_rvalid} !== {1'b0, k < 3, 1'b0, k >= 2}) begin
                errors++; $display("FAIL sb_handshake[%0d]: got g %b%b rv %b%b expected g 0%b rv 0%b", k,
                                   ifa.ARB_p0_gnt, ifa.ARB_p1_gnt, ifa.ARB_p0_rvalid, ifa.ARB_p1_rvalid, k < 3, k >= 2);
            end
            if (k == 4) begin
                checks++;
                if (ifa.ARB_rdata !== 32'h1122AA44) begin
                    errors++; $display("FAIL sb_rdata: got %h expected 1122aa44", ifa.ARB_rdata);
                end
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k < 3)      set_a(1'b0, MEM_IDLE, '0, '0, 1'b1, MEM_SW, 32'h40 + 32'(4 * k), 32'hA0000000 + 32'(k));
            else if (k < 6) set_a(1'b0, MEM_IDLE, '0, '0, 1'b1, MEM_LW, 32'h40 + 32'(4 * (k - 3)), '0);
            else            idle_a();
            #1;
            checks++;
            if ({ifa.ARB_p0_gnt, ifa.ARB_p1_gnt} !== {1'b0, k < 6}) begin
                errors++; $display("FAIL b2b_gnt[%0d]: got %b%b expected 0%b", k, ifa.ARB_p0_gnt, ifa.ARB_p1_gnt, k < 6);
            end
            checks++;
            if ({ifa.ARB_p0_rvalid, ifa.ARB_p1_rvalid} !== {1'b0, k >= 2}) begin
                errors++; $display("FAIL b2b_rvalid[%0d]: got %b%b expected 0%b", k,
                                   ifa.ARB_p0_rvalid, ifa.ARB_p1_rvalid, k >= 2);
            end
            if (k >= 5) begin
                checks++;
                if (ifa.ARB_rdata !== 32'hA0000000 + 32'(k - 5)) begin
                    errors++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", k, ifa.ARB_rdata, 32'hA0000000 + 32'(k - 5));
                end
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_inflight;
        logic e1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            rst = (k == 3);
            set_a(1'b1, MEM_LW, 32'h30, '0, 1'b1, MEM_LW, 32'h34, '0);
            #1;
            // After reset the starvation count restarts, so port 1 waits a full burst again.
            e1 = (k == 8);
            checks++;
            if ({ifa.ARB_p0_gnt, ifa.ARB_p1_gnt} !== ((k == 3) ? 2'b00 : {!e1, e1})) begin
                errors++; $display("FAIL rstfl_gnt[%0d]: got %b%b expected %b", k, ifa.ARB_p0_gnt, ifa.ARB_p1_gnt,
                                   (k == 3) ? 2'b00 : {!e1, e1});
            end
            checks++;
            if ({ifa.ARB_p0_rvalid, ifa.ARB_p1_rvalid} !== {(k == 2 || k == 3 || k >= 6), 1'b0}) begin
                errors++; $display("FAIL rstfl_rvalid[%0d]: got %b%b expected %b0", k,
                                   ifa.ARB_p0_rvalid, ifa.ARB_p1_rvalid, (k == 2 || k == 3 || k >= 6));
            end
            if (k == 4) begin
                checks++;
                if (ifa.ARB_mem_cmd !== MEM_IDLE) begin
                    errors++; $display("FAIL rstfl_cmd: got %h expected 0", ifa.ARB_mem_cmd);
                end
            end
        end
        @(negedge clk);
        idle_a();
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        int          due;
        logic        port;
        logic        ld;
        logic [31:0] data;
    } resp_t;

    logic [31:0] model_mem [256];

    function automatic logic [3:0] pick_cmd(input int n);
        case (n)
            0:       return MEM_LW;
            1:       return MEM_LB;
            2:       return MEM_LHU;
            3:       return MEM_SB;
            4:       return MEM_SH;
            default: return MEM_SW;
        endcase
    endfunction

    task automatic test_random;
        resp_t       rq[$];
        resp_t       r;
        logic        pend0, pend1, eg0, eg1, ev0, ev1, eld;
        logic [3:0]  c0, c1;
        logic [31:0] a0, a1, d0, d1, edata;
        int          p1_wait;

        @(negedge clk);
        rst = 1'b1;
        idle_a();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        pend0 = 1'b0; pend1 = 1'b0; p1_wait = 0;
        c0 = MEM_IDLE; c1 = MEM_IDLE; a0 = '0; a1 = '0; d0 = '0; d1 = '0;

        for (int k = 0; k < 420; k++) begin
            @(negedge clk);
            if (!pend0 && k < 400 && $urandom_range(0, 1) == 1) begin
                pend0 = 1'b1; c0 = pick_cmd(int'($urandom_range(0, 5)));
                a0 = 32'($urandom_range(0, 63)); d0 = $urandom;
            end
            if (!pend1 && k < 400 && $urandom_range(0, 3) != 0) begin
                pend1 = 1'b1; c1 = pick_cmd(int'($urandom_range(0, 5)));
                a1 = 32'($urandom_range(0, 63)); d1 = $urandom;
            end
            set_a(pend0, c0, a0, d0, pend1, c1, a1, d1);
            #1;
            // Port 1 wins when alone or once it has waited out a full port-0 burst.
            eg1 = pend1 && (!pend0 || p1_wait == MAX_BURST_A);
            eg0 = pend0 && !eg1;
            checks++;
            if ({ifa.ARB_p0_gnt, ifa.ARB_p1_gnt} !== {eg0, eg1}) begin
                errors++; $display("FAIL rnd_gnt[%0d]: got %b%b expected %b%b", k, ifa.ARB_p0_gnt, ifa.ARB_p1_gnt, eg0, eg1);
            end
            ev0 = 1'b0; ev1 = 1'b0; eld = 1'b0; edata = '0;
            if (rq.size() > 0 && rq[0].due == k) begin
                r = rq.pop_front();
                ev0 = !r.port; ev1 = r.port; eld = r.ld; edata = r.data;
            end
            checks++;
            if ({ifa.ARB_p0_rvalid, ifa.ARB_p1_rvalid} !== {ev0, ev1}) begin
                errors++; $display("FAIL rnd_rvalid[%0d]: got %b%b expected %b%b", k,
                                   ifa.ARB_p0_rvalid, ifa.ARB_p1_rvalid, ev0, ev1);
            end
            if (eld) begin
                checks++;
                if (ifa.ARB_rdata !== edata) begin
                    errors++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", k, ifa.ARB_rdata, edata);
                end
            end
            if (eg0 || eg1) begin
                r.due  = k + 2;
                r.port = eg1;
                r.ld   = !is_store(eg1 ? c1 : c0);
                r.data = model_mem[eg1 ? a1[9:2] : a0[9:2]];
                rq.push_back(r);
                if (eg1) model_mem[a1[9:2]] = merge(model_mem[a1[9:2]], c1, a1[1:0], d1);
                else     model_mem[a0[9:2]] = merge(model_mem[a0[9:2]], c0, a0[1:0], d0);
            end
            p1_wait = eg1 ? 0 : (pend1 ? p1_wait + 1 : 0);
            if (eg0) pend0 = 1'b0;
            if (eg1) pend1 = 1'b0;
        end
        checks++;
        if (rq.size() != 0 || pend0 || pend1) begin
            errors++; $display("FAIL rnd_drain: got %0d responses and pending %b%b outstanding expected none",
                               rq.size(), pend0, pend1);
        end
        idle_a();
    endtask

    initial begin
        rst = 1'b1;
        idle_a();
        set_b(1'b0, 1'b0);
        test_reset();
        test_store_load();
        test_contention4();
        test_alternate1();
        test_byte_store();
        test_back_to_back();
        test_reset_inflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
